// File: rtl/fir_band_sched.sv
// fir_band_sched: time-multiplexes one FIR MAC core across NUM_BANDS bands.
// For each accepted sample it runs one coefficient sweep per enabled band
// (ascending index) and captures the core output into a per-band slice.
// Ports:
//   clk, rst             clock, async active-high reset
//   smpl_vld/smpl_rdy    sample handshake (ready only in IDLE)
//   band_en              band enable mask, sampled on accept
//   sequencing           drives the core sequencing input
//   band_sel             active band (coefficient ROM / sample queue select)
//   cff_ptr              core coefficient pointer (sequence check only)
//   core_smpl_out        core filter output
//   band_out             per-band results, band b at [16b+15:16b]
//   out_vld              one-cycle pulse, all slices valid
//   ovr, seq_err         sticky overrun / pointer-mismatch flags
// Optional: define FIR_SCHED_SEQCHK_EN to enable the end-of-sweep pointer
// check; otherwise cff_ptr is unused and seq_err is tied 0.
module fir_band_sched #(
    parameter int NUM_BANDS = 4,
    parameter int NUM_COEFF = 1021
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        smpl_vld,
    output logic                        smpl_rdy,
    input  logic [NUM_BANDS-1:0]        band_en,
    output logic                        sequencing,
    output logic [$clog2(NUM_BANDS)-1:0] band_sel,
    input  logic [9:0]                  cff_ptr,
    input  logic [15:0]                 core_smpl_out,
    output logic [16*NUM_BANDS-1:0]     band_out,
    output logic                        out_vld,
    output logic                        ovr,
    output logic                        seq_err
);

    localparam int SW = $clog2(NUM_BANDS);
    localparam int TW = $clog2(NUM_COEFF + 2);

    typedef enum logic [2:0] {
        IDLE, RUN, SETTLE, CAPT, DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       tap;
    logic [NUM_BANDS-1:0] en_q;
    logic [SW-1:0]       sel_q;
    logic                tap_last;
    logic                first_found;
    logic [SW-1:0]       first_idx;
    logic                nxt_found;
    logic [SW-1:0]       nxt_idx;

    assign tap_last = (tap == TW'(NUM_COEFF));
    assign band_sel = sel_q;

    // Lowest enabled band in the live mask (used at accept).
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (band_en[i]) begin
                first_found = 1'b1;
                first_idx   = SW'(i);
            end
        end
    end

    // Lowest latched-enabled band above the current one.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(sel_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = SW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (smpl_vld) state_nxt = first_found ? RUN : DONE;
            end
            RUN: begin
                if (tap_last) state_nxt = SETTLE;
            end
            SETTLE: state_nxt = CAPT;
            CAPT:   state_nxt = nxt_found ? RUN : DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        smpl_rdy   = (state == IDLE);
        sequencing = (state == RUN);
        out_vld    = (state == DONE);
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap      <= '0;
            en_q     <= '0;
            sel_q    <= '0;
            band_out <= '0;
            ovr      <= 1'b0;
        end else begin
            if (state == RUN) tap <= tap_last ? '0 : tap + 1'b1;
            if (smpl_vld && state != IDLE) ovr <= 1'b1;
            if (state == IDLE && smpl_vld) begin
                en_q <= band_en;
                if (first_found) sel_q <= first_idx;
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (!band_en[b]) band_out[16*b +: 16] <= '0;
                end
            end
            if (state == CAPT) begin
                band_out[16*int'(sel_q) +: 16] <= core_smpl_out;
                if (nxt_found) sel_q <= nxt_idx;
            end
        end
    end

`ifdef FIR_SCHED_SEQCHK_EN
    // Core must present its done pointer in the cycle after the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err <= 1'b0;
        end else if (state == SETTLE && cff_ptr != 10'(NUM_COEFF + 1)) begin
            seq_err <= 1'b1;
        end
    end
`else
    logic unused_cff_ptr;
    assign unused_cff_ptr = ^cff_ptr;
    assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fir_band_sched.sv
// Self-checking bench for fir_band_sched: core model returns base+band,
// scoreboard holds expected band_out and out_vld cycle per sample.
module tb_fir_band_sched;

    localparam int NB = 4;
    localparam int NC = 1021;
    localparam int PER_BAND = NC + 3;

    logic            clk = 0;
    logic            rst = 1;
    logic            smpl_vld = 0;
    logic            smpl_rdy;
    logic [NB-1:0]   band_en = '0;
    logic            sequencing;
    logic [1:0]      band_sel;
    logic [9:0]      cff_ptr;
    logic [15:0]     core_smpl_out;
    logic [16*NB-1:0] band_out;
    logic            out_vld;
    logic            ovr;
    logic            seq_err;

    logic [15:0]     base = 16'h0;
    logic [9:0]      ptr_q;
    logic            inj = 0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [16*NB-1:0] bo;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic [16*NB-1:0] model = '0;

`ifdef FIR_SCHED_SEQCHK_EN
    localparam logic SEQCHK = 1'b1;
`else
    localparam logic SEQCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    fir_band_sched #(.NUM_BANDS(NB), .NUM_COEFF(NC)) dut (
        .clk(clk),
        .rst(rst),
        .smpl_vld(smpl_vld),
        .smpl_rdy(smpl_rdy),
        .band_en(band_en),
        .sequencing(sequencing),
        .band_sel(band_sel),
        .cff_ptr(cff_ptr),
        .core_smpl_out(core_smpl_out),
        .band_out(band_out),
        .out_vld(out_vld),
        .ovr(ovr),
        .seq_err(seq_err)
    );

    // Core model: pointer advances while sequencing, done pointer held
    // one cycle after sequencing drops, then back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             ptr_q <= '0;
        else if (sequencing) ptr_q <= ptr_q + 1'b1;
        else                 ptr_q <= '0;
    end

    assign cff_ptr = (inj && !sequencing && band_sel == 2'd1) ? 10'd1000 : ptr_q;
    assign core_smpl_out = base + 16'(band_sel);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_sample(input logic [NB-1:0] en, input logic [15:0] b,
                             input int pulse_at, input int rst_at,
                             input logic inject);
        int   n, cyc, run_len, gap, bursts;
        logic prev_seq, got;
        int   exp_sel[$];
        exp_t item;
        n = 0;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) begin
                model[16*i +: 16] = b + 16'(i);
                exp_sel.push_back(i);
                n++;
            end else begin
                model[16*i +: 16] = '0;
            end
        end
        sb.push_back('{model, 1 + n * PER_BAND});
        base = b;
        inj = inject;
        band_en = en;
        smpl_vld = 1;
        @(posedge clk);
        cyc = 0; run_len = 0; gap = 0; bursts = 0;
        prev_seq = 0; got = 0;
        while (!got && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                smpl_vld = 0;
                band_en = ~en;
            end
            if (cyc == pulse_at) smpl_vld = 1;
            if (cyc == pulse_at + 1) smpl_vld = 0;
            if (cyc == rst_at) begin
                rst = 1;
                #1;
                chk("rst_seq", 64'(sequencing), 64'd0);
                chk("rst_bo", 64'(band_out), 64'd0);
                chk("rst_vld", 64'(out_vld), 64'd0);
                chk("rst_ovr", 64'(ovr), 64'd0);
                chk("rst_serr", 64'(seq_err), 64'd0);
                void'(sb.pop_front());
                model = '0;
                @(negedge clk);
                rst = 0;
                inj = 0;
                return;
            end
            if (inject && cyc == 2047)
                chk("serr_pre", 64'(seq_err), 64'd0);
            if (inject && cyc == 2048)
                chk("serr_set", 64'(seq_err), 64'(SEQCHK));
            if (sequencing && !prev_seq) begin
                if (exp_sel.size() > 0)
                    chk("band_sel", 64'(band_sel), 64'(exp_sel.pop_front()));
                else
                    chk("extra_burst", 64'd1, 64'd0);
                if (bursts > 0) chk("gap", 64'(gap), 64'd2);
                bursts++;
                run_len = 1;
            end else if (sequencing) begin
                run_len++;
            end else if (prev_seq) begin
                chk("run_len", 64'(run_len), 64'(NC + 1));
                gap = 1;
            end else begin
                gap++;
            end
            prev_seq = sequencing;
            if (out_vld) begin
                item = sb.pop_front();
                chk("vld_cyc", 64'(cyc), 64'(item.cyc));
                chk("band_out", 64'(band_out), 64'(item.bo));
                got = 1;
            end
        end
        if (!got) chk("timeout", 64'd1, 64'd0);
        chk("bursts", 64'(bursts), 64'(n));
        @(negedge clk);
        chk("rdy_after", 64'(smpl_rdy), 64'd1);
        chk("vld_pulse", 64'(out_vld), 64'd0);
        inj = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("r_rdy", 64'(smpl_rdy), 64'd1);
        chk("r_seq", 64'(sequencing), 64'd0);
        chk("r_sel", 64'(band_sel), 64'd0);
        chk("r_bo", 64'(band_out), 64'd0);
        chk("r_vld", 64'(out_vld), 64'd0);
        chk("r_ovr", 64'(ovr), 64'd0);
        chk("r_serr", 64'(seq_err), 64'd0);

        do_sample(4'b1111, 16'h1000, -1, -1, 1'b1);
        chk("serr_final", 64'(seq_err), 64'(SEQCHK));
        chk("ovr_clean", 64'(ovr), 64'd0);

        do_sample(4'b0101, 16'h2000, -1, -1, 1'b0);
        do_sample(4'b0000, 16'h2800, -1, -1, 1'b0);

        do_sample(4'b1111, 16'h3000, 500, -1, 1'b0);
        chk("ovr_set", 64'(ovr), 64'd1);

        do_sample(4'b1111, 16'h4000, -1, 1500, 1'b0);
        do_sample(4'b0110, 16'h5000, -1, -1, 1'b0);
        do_sample(4'b1011, 16'h6000, -1, -1, 1'b0);
        chk("ovr_after_rst", 64'(ovr), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
